// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Runs iterative mul/div, stalls EX while busy, and emits one-cycle HI/LO
// write strobes and data.
// Ports: clk, rst_n, start, op[2:0], src_a, src_b, flush in;
// stall, done, hi_we, hi_wdata, lo_we, lo_wdata out.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        hi_we,
  output logic [31:0] hi_wdata,
  output logic        lo_we,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_lo;
  logic        neg_hi;
  logic        we_hi_q;
  logic        we_lo_q;

  logic        idle;
  logic        mul_req;
  logic        div_req;
  logic        div_zero;
  logic        div_go;
  logic        mthi_req;
  logic        mtlo_req;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        long_req;

  assign idle      = (state == IDLE);
  assign mul_req   = start && (op == 3'd0 || op == 3'd1);
  assign div_req   = start && (op == 3'd2 || op == 3'd3);
  assign div_zero  = div_req && (src_b == 32'd0);
  assign div_go    = div_req && (src_b != 32'd0);
  assign mthi_req  = start && (op == 3'd4);
  assign mtlo_req  = start && (op == 3'd5);
  assign signed_op = (op == 3'd0 || op == 3'd2);
  assign a_neg     = signed_op && src_a[31];
  assign b_neg     = signed_op && src_b[31];
  assign a_mag     = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag     = b_neg ? (~src_b + 32'd1) : src_b;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] fast_prod;
  // Low 64 bits of a sign-extended product equal the signed product.
  assign ext_a     = {{32{a_neg}}, src_a};
  assign ext_b     = {{32{b_neg}}, src_b};
  assign fast_prod = ext_a * ext_b;
  assign long_req  = idle && div_go;
`else
  assign long_req  = idle && (mul_req || div_go);
`endif

  assign stall = rst_n && !flush &&
                 (state == MUL || state == DIV || long_req);
  assign done  = (state == DONE) && !flush;
  assign hi_we = we_hi_q && (state == DONE) && !flush;
  assign lo_we = we_lo_q && (state == DONE) && !flush;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_res;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [32:0] div_rem;
  logic [63:0] div_next;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  // acc = {partial product, remaining multiplier} for MUL,
  // acc = {partial remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} +
               (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    mul_res  = neg_lo ? (~mul_next + 64'd1) : mul_next;
    div_sh   = {acc[63:32], acc[31]};
    div_ge   = (div_sh >= {1'b0, opnd});
    div_rem  = div_ge ? (div_sh - {1'b0, opnd}) : div_sh;
    div_next = {div_rem[31:0], acc[30:0], div_ge};
    quo_res  = neg_lo ? (~div_next[31:0] + 32'd1) : div_next[31:0];
    rem_res  = neg_hi ? (~div_next[63:32] + 32'd1) : div_next[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      we_hi_q  <= 1'b0;
      we_lo_q  <= 1'b0;
      hi_wdata <= 32'd0;
      lo_wdata <= 32'd0;
    end else if (flush) begin
      state   <= IDLE;
      we_hi_q <= 1'b0;
      we_lo_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            mul_req: begin
`ifdef MULDIV_FAST_MUL_EN
              state    <= DONE;
              hi_wdata <= fast_prod[63:32];
              lo_wdata <= fast_prod[31:0];
              we_hi_q  <= 1'b1;
              we_lo_q  <= 1'b1;
`else
              state  <= MUL;
              cnt    <= 5'd0;
              acc    <= {32'd0, b_mag};
              opnd   <= a_mag;
              neg_lo <= a_neg ^ b_neg;
`endif
            end
            div_go: begin
              state  <= DIV;
              cnt    <= 5'd0;
              acc    <= {32'd0, a_mag};
              opnd   <= b_mag;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
            end
            div_zero: begin
              state    <= DONE;
              hi_wdata <= src_a;
              lo_wdata <= 32'hFFFF_FFFF;
              we_hi_q  <= 1'b1;
              we_lo_q  <= 1'b1;
            end
            mthi_req: begin
              state    <= DONE;
              hi_wdata <= src_a;
              we_hi_q  <= 1'b1;
              we_lo_q  <= 1'b0;
            end
            mtlo_req: begin
              state    <= DONE;
              lo_wdata <= src_a;
              we_hi_q  <= 1'b0;
              we_lo_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= DONE;
            hi_wdata <= mul_res[63:32];
            lo_wdata <= mul_res[31:0];
            we_hi_q  <= 1'b1;
            we_lo_q  <= 1'b1;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= DONE;
            hi_wdata <= rem_res;
            lo_wdata <= quo_res;
            we_hi_q  <= 1'b1;
            we_lo_q  <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          we_hi_q <= 1'b0;
          we_lo_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against
// an arithmetic reference model.
module tb_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic        hi_we;
  logic [31:0] hi_wdata;
  logic        lo_we;
  logic [31:0] lo_wdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [2:0]  mop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] eh,
    output logic [31:0] el,
    output logic        wh,
    output logic        wl,
    output logic        lng
  );
    longint          sp;
    longint unsigned up;
    longint          sq;
    longint          sr;
    eh  = last_hi;
    el  = last_lo;
    wh  = 1'b1;
    wl  = 1'b1;
    lng = 1'b0;
    case (mop)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        eh = sp[63:32];
        el = sp[31:0];
        lng = !FAST;
      end
      3'd1: begin
        up = 64'(a) * 64'(b);
        eh = up[63:32];
        el = up[31:0];
        lng = !FAST;
      end
      3'd2: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          el = sq[31:0];
          eh = sr[31:0];
          lng = 1'b1;
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          el = a / b;
          eh = a % b;
          lng = 1'b1;
        end
      end
      3'd4: begin
        eh = a;
        wl = 1'b0;
      end
      default: begin
        el = a;
        wh = 1'b0;
      end
    endcase
  endfunction

  // Presents one request and waits for the completion cycle.
  // cyc counts cycles after the acceptance cycle (which is cycle 0).
  task automatic run_op(
    input  logic [2:0]  mop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          cyc,
    output int          nst,
    output logic        ok,
    output logic [3:0]  flags,
    output logic [31:0] oh,
    output logic [31:0] ol
  );
    ok  = 1'b0;
    cyc = 0;
    nst = 0;
    flags = 4'd0;
    oh = 32'd0;
    ol = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = mop;
    src_a = a;
    src_b = b;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      if (stall) nst++;
      if (done || hi_we || lo_we) begin
        ok    = 1'b1;
        flags = {done, hi_we, lo_we, stall};
        oh    = hi_wdata;
        ol    = lo_wdata;
      end else begin
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    op    = 3'd0;
    src_a = 32'd3;
    src_b = 32'd5;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, done, hi_we, lo_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=0000",
               {stall, done, hi_we, lo_we});
    end
    checks++;
    if (hi_wdata !== 32'd0 || lo_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h exp=0/0", hi_wdata, lo_wdata);
    end
    start = 1'b0;
    rst_n = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;
  endtask

  task automatic check_op(
    input string        nm,
    input logic [2:0]   mop,
    input logic [31:0]  a,
    input logic [31:0]  b
  );
    logic [31:0] eh, el, oh, ol;
    logic wh, wl, lng, ok;
    logic [3:0] fl;
    int cyc, nst, ecyc, est;
    model(mop, a, b, eh, el, wh, wl, lng);
    ecyc = lng ? 33 : 1;
    est  = lng ? 33 : 0;
    run_op(mop, a, b, cyc, nst, ok, fl, oh, ol);
    checks++;
    if (!ok || cyc !== ecyc || nst !== est) begin
      errors++;
      $display("FAIL %s timing op=%0d ok=%b cyc=%0d stall=%0d exp cyc=%0d stall=%0d",
               nm, mop, ok, cyc, nst, ecyc, est);
    end
    checks++;
    if (fl !== {1'b1, wh, wl, 1'b0}) begin
      errors++;
      $display("FAIL %s strobes op=%0d got=%b exp=%b",
               nm, mop, fl, {1'b1, wh, wl, 1'b0});
    end
    checks++;
    if (oh !== eh || ol !== el) begin
      errors++;
      $display("FAIL %s data op=%0d a=%h b=%h got=%h/%h exp=%h/%h",
               nm, mop, a, b, oh, ol, eh, el);
    end
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic test_directed;
    check_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5);
    check_op("divu_100_7", 3'd3, 32'd100, 32'd7);
    check_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check_op("div_by_zero", 3'd2, 32'h1234_5678, 32'd0);
    check_op("mtlo", 3'd5, 32'hA5A5_A5A5, 32'd0);
    check_op("mthi", 3'd4, 32'h5A5A_0001, 32'd9);
    check_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_random;
    logic [2:0]  mop;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      mop = 3'($urandom_range(0, 5));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      check_op("random", mop, a, b);
    end
  endtask

  task automatic test_undefined_op;
    int bad;
    bad = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'd6;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'd3;
    @(negedge clk);
    if (stall) bad++;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (stall || done || hi_we || lo_we) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL undef_op activity=%0d exp=0", bad);
    end
    check_op("after_undef", 3'd5, 32'h0BAD_F00D, 32'd0);
  endtask

  task automatic test_flush;
    int bad;
    bad = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'd3;
    src_a = 32'd1000;
    src_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got=%b exp=0", stall);
    end
    if (done || hi_we || lo_we) bad++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (stall || done || hi_we || lo_we) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL flush_nowrite activity=%0d exp=0", bad);
    end
    check_op("mthi_after_flush", 3'd4, 32'h1357_9BDF, 32'd0);
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    check_op("pre_reset", 3'd3, 32'd77, 32'd5);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'd0;
    src_a = 32'hFFFF_FFFD;
    src_b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, done, hi_we, lo_we} !== 4'b0000 ||
        hi_wdata !== 32'd0 || lo_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b %h/%h exp=0000 0/0",
               {stall, done, hi_we, lo_we}, hi_wdata, lo_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;
    repeat (40) begin
      @(negedge clk);
      if (stall || done || hi_we || lo_we) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_mid_nowrite activity=%0d exp=0", bad);
    end
    check_op("mtlo_after_reset", 3'd5, 32'h2468_ACE0, 32'd0);
  endtask

  task automatic test_back_to_back;
    check_op("b2b_mthi", 3'd4, 32'h1111_2222, 32'd0);
    check_op("b2b_mtlo", 3'd5, 32'h3333_4444, 32'd0);
    check_op("b2b_divz", 3'd3, 32'h5555_6666, 32'd0);
    check_op("b2b_mult", 3'd0, 32'd12, 32'hFFFF_FFFE);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_undefined_op();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
